alu_mc: RTL and testbench
=========================

// Module: alu_mc
// PURPOSE
//  Parametrised multi-cycle ALU: next generation of the single-cycle 8-bit alu. Sits between
//  decode/regfile read and writeback in the core datapath. Adds a W-bit datapath, a
//  valid/ready handshake on both sides, iterative shift/multiply, registered flags and abort.
// PARAMETERS
//  W      8      operand/result width (>=4)
//  SHW    $clog2(W)  shift-amount bits taken from inB[SHW-1:0]
// PORTS
//  Clk        in   1    clock, rising edge
//  Reset_n    in   1    asynchronous active-low reset
//  in_valid   in   1    operands/op presented
//  in_ready   out  1    ALU idle, accepts a transfer
//  ALUOp      in   3    operation (alu_op_e)
//  inA        in   W    operand A
//  inB        in   W    operand B (shift amount for SHL/SHR)
//  abort      in   1    sync: drop current op/result
//  out_valid  out  1    rslt/flags/taken valid
//  out_ready  in   1    consumer accepts the result
//  rslt       out  W    result
//  flags      out  3    {neg, carry, zero}
//  taken      out  1    branch condition
// BEHAVIOUR
//  Reset: async. State=IDLE; rslt=0, flags=0, taken=0, out_valid=0, in_ready=1 (IDLE).
//  No transfer can occur while Reset_n is low.
//  Op map: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR (logical), 111 MUL.
//  Accept on in_valid&&in_ready; op and operands are latched. in_ready = (state==IDLE).
//  FSM: IDLE -> DONE (ADD..XOR, or shift with amount 0)
//       IDLE -> BUSY (shift with amount != 0, or MUL)
//       BUSY -> DONE when the iteration counter hits 0
//       DONE -> IDLE on out_ready
//  Latency (accept edge to out_valid): 1 cycle for ADD..XOR; amt+1 for shifts
//  (amt = inB[SHW-1:0], one bit per cycle); W+1 for MUL (shift-add, one bit per cycle).
//  Arithmetic: ADD carry=carry-out of W-bit sum. SUB carry=borrow (A<B unsigned).
//  Shifts: carry=last bit shifted out; 0 if amt=0. MUL: rslt = low W bits; carry = |upper W bits.
//  Logic ops: carry=0.
//  Flags: zero=(rslt==0); neg=rslt[W-1]; taken = (op==SUB) && (inA==inB); else taken=0.
//  All outputs are registered; rslt/flags/taken update only on entry to DONE.
//  DONE: out_valid=1; outputs hold stable while out_ready=0. in_ready=0, so in_valid is ignored.
//  Leaving DONE drops out_valid the next cycle; outputs keep their last value.
//  No accept in the same cycle as the result handoff (one op in flight).
//  abort: in BUSY or DONE -> IDLE next edge, out_valid=0, result discarded, outputs unchanged.
//  In IDLE abort has priority and blocks the transfer (in_ready is still high; the op is
//  not accepted).
//  Reset mid-operation: immediate clear to reset values; the op is lost.
//  ALUOp is a full 3-bit decode; there are no illegal codes.
// STRUCTURE
//  alu_pkg: alu_op_e enum (8 ops above); alu_state_e {IDLE, BUSY, DONE}; flag bit-index localparams.
//  Sub-module alu_iter_unit: iterative shift/multiply datapath with counter and done pulse.
//  Top holds the FSM, single-cycle ops, flag generation and output registers.
// TESTING (W=8)
//  1 ADD 0x7F+0x01 -> rslt 0x80, flags {1,0,0}, out_valid 1 cycle after accept.
//  2 SUB 0x11-0x11 -> rslt 0x00, zero=1, taken=1.
//    SUB 0x00-0x01 -> rslt 0xFF, carry=1, neg=1, taken=0.
//  3 SHR 0xA0 by 6 -> rslt 0x02, carry=1, latency 7.
//    SHL 0x01 by 0 -> rslt 0x01, carry=0, latency 1.
//  4 MUL 0x10*0x11 -> rslt 0x10, carry=1, latency 9. MUL 0x0F*0x0F -> rslt 0xE1, carry=0.
//  5 Backpressure: out_ready=0 for 5 cycles with in_valid=1 -> rslt/flags stable,
//    in_ready=0, no new accept.
//  6 Reset_n low in MUL BUSY -> outputs 0 immediately, in_ready=1 after release.
//    abort in DONE -> out_valid 0 next cycle, next op accepted normally.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared types for the multi-cycle ALU. It holds the operation
//                encoding, the FSM state encoding, the bit positions inside
//                the flags vector, and a small helper that classifies ops.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SHL = 3'b101,
        ALU_SHR = 3'b110,
        ALU_MUL = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } alu_state_e;

    // Bit positions inside the flags output {neg, carry, zero}
    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_NEG   = 2;

    function automatic logic is_shift(input alu_op_e op);
        return (op == ALU_SHL) || (op == ALU_SHR);
    endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_iter_unit.sv
`default_nettype none
// ============================================================================
//  Module      : alu_iter_unit
//  Description : Iterative datapath for SHL, SHR and MUL. Each cycle it
//                processes one bit. It presents the value of the step in
//                progress on o_res/o_carry. o_done is high during the final
//                step, so the caller captures o_res on that same edge.
//  Ports       : clk/rst_n  - clock, asynchronous active-low reset
//                i_start    - load the operands and begin iterating
//                i_abort    - stop iterating and drop the operation
//                i_op       - SHL, SHR or MUL
//                i_a, i_b   - operand A, operand B (i_b[SHW-1:0] is the shift amount)
//                o_done     - final step in progress
//                o_res      - result after the current step
//                o_carry    - carry after the current step
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_iter_unit
    import alu_pkg::*;
#(
    parameter int W   = 8,
    parameter int SHW = $clog2(W),
    parameter int CW  = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_start,
    input  logic          i_abort,
    input  alu_op_e       i_op,
    input  logic [W-1:0]  i_a,
    input  logic [W-1:0]  i_b,
    output logic          o_done,
    output logic [W-1:0]  o_res,
    output logic          o_carry
);

    logic            r_busy;
    alu_op_e         r_op;
    logic [2*W-1:0]  r_prod;   // MUL: {acc, multiplier}; shifts: value in low W bits
    logic [W-1:0]    r_mcand;
    logic [CW-1:0]   r_cnt;

    logic [2*W-1:0]  w_prod_nxt;
    logic [W:0]      w_sum;
    logic            w_carry;

    // Shift-add multiply works on the multiplier LSB. The accumulator takes the
    // sum, and the pair shifts right so the product fills the register from the top.
    always_comb begin
        w_prod_nxt = r_prod;
        w_sum      = '0;
        w_carry    = 1'b0;
        case (r_op)
            ALU_SHL: begin
                w_prod_nxt = {{W{1'b0}}, r_prod[W-2:0], 1'b0};
                w_carry    = r_prod[W-1];
            end
            ALU_SHR: begin
                w_prod_nxt = {{W{1'b0}}, 1'b0, r_prod[W-1:1]};
                w_carry    = r_prod[0];
            end
            ALU_MUL: begin
                w_sum      = {1'b0, r_prod[2*W-1:W]} + {1'b0, (r_prod[0] ? r_mcand : {W{1'b0}})};
                w_prod_nxt = {w_sum, r_prod[W-1:1]};
                w_carry    = |w_prod_nxt[2*W-1:W];
            end
            default: ;
        endcase
    end

    assign o_done  = r_busy && (r_cnt == CW'(1));
    assign o_res   = w_prod_nxt[W-1:0];
    assign o_carry = w_carry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy  <= 1'b0;
            r_op    <= ALU_ADD;
            r_prod  <= '0;
            r_mcand <= '0;
            r_cnt   <= '0;
        end else if (i_abort) begin
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_busy  <= 1'b1;
            r_op    <= i_op;
            r_mcand <= i_a;
            if (i_op == ALU_MUL) begin
                r_prod <= {{W{1'b0}}, i_b};
                r_cnt  <= CW'(W);
            end else begin
                r_prod <= {{W{1'b0}}, i_a};
                r_cnt  <= CW'(i_b[SHW-1:0]);
            end
        end else if (r_busy) begin
            r_prod <= w_prod_nxt;
            r_cnt  <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule : alu_iter_unit
`default_nettype wire

// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
//  Module      : alu_mc
//  Description : Multi-cycle W-bit ALU with valid/ready handshakes on the input
//                and output sides, registered result and flags, and an abort
//                input. ADD/SUB/AND/OR/XOR, and shifts by zero, complete in one
//                cycle. Other shifts and MUL go through alu_iter_unit.
//  Ports       : Clk, Reset_n      - clock, asynchronous active-low reset
//                in_valid/in_ready - operand handshake
//                ALUOp, inA, inB   - operation and operands
//                abort             - drop the current op or result
//                out_valid/out_ready - result handshake
//                rslt, flags, taken  - result, {neg,carry,zero}, branch condition
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_mc
    import alu_pkg::*;
#(
    parameter int W   = 8,
    parameter int SHW = $clog2(W)
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    ALUOp,
    input  logic [W-1:0]  inA,
    input  logic [W-1:0]  inB,
    input  logic          abort,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  rslt,
    output logic [2:0]    flags,
    output logic          taken
);

    alu_state_e    r_state, w_state_nxt;
    logic [W-1:0]  r_rslt;
    logic [2:0]    r_flags;
    logic          r_taken;
    logic          r_out_valid;
    logic          r_in_ready;

    alu_op_e       w_op;
    logic          w_accept;
    logic          w_is_iter;
    logic [W:0]    w_sum;
    logic [W-1:0]  w_sc_res;
    logic          w_sc_carry;
    logic          w_it_done;
    logic [W-1:0]  w_it_res;
    logic          w_it_carry;
    logic          w_load_sc;
    logic          w_load_it;
    logic [W-1:0]  w_fin_res;
    logic          w_fin_carry;

    assign w_op      = alu_op_e'(ALUOp);
    // Abort wins over a transfer in IDLE even though in_ready is high
    assign w_accept  = in_valid && (r_state == ST_IDLE) && !abort;
    assign w_is_iter = (w_op == ALU_MUL) || (is_shift(w_op) && (inB[SHW-1:0] != '0));

    // Single-cycle ops. A shift by zero falls to the default: result A, carry 0.
    always_comb begin
        w_sum      = '0;
        w_sc_res   = inA;
        w_sc_carry = 1'b0;
        case (w_op)
            ALU_ADD: begin
                w_sum      = {1'b0, inA} + {1'b0, inB};
                w_sc_res   = w_sum[W-1:0];
                w_sc_carry = w_sum[W];
            end
            ALU_SUB: begin
                w_sum      = {1'b0, inA} - {1'b0, inB};
                w_sc_res   = w_sum[W-1:0];
                w_sc_carry = w_sum[W];          // borrow: A < B unsigned
            end
            ALU_AND: w_sc_res = inA & inB;
            ALU_OR:  w_sc_res = inA | inB;
            ALU_XOR: w_sc_res = inA ^ inB;
            default: ;
        endcase
    end

    alu_iter_unit #(
        .W   (W),
        .SHW (SHW)
    ) u_iter (
        .clk     (Clk),
        .rst_n   (Reset_n),
        .i_start (w_accept && w_is_iter),
        .i_abort (abort),
        .i_op    (w_op),
        .i_a     (inA),
        .i_b     (inB),
        .o_done  (w_it_done),
        .o_res   (w_it_res),
        .o_carry (w_it_carry)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = w_is_iter ? ST_BUSY : ST_DONE;
            ST_BUSY: begin
                if (abort)          w_state_nxt = ST_IDLE;
                else if (w_it_done) w_state_nxt = ST_DONE;
            end
            ST_DONE: if (abort || out_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_load_sc   = w_accept && !w_is_iter;
    assign w_load_it   = (r_state == ST_BUSY) && !abort && w_it_done;
    assign w_fin_res   = w_load_sc ? w_sc_res   : w_it_res;
    assign w_fin_carry = w_load_sc ? w_sc_carry : w_it_carry;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= ST_IDLE;
            r_rslt      <= '0;
            r_flags     <= '0;
            r_taken     <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= (w_state_nxt == ST_DONE);
            r_in_ready  <= (w_state_nxt == ST_IDLE);
            if (w_load_sc || w_load_it) begin
                r_rslt              <= w_fin_res;
                r_flags[FLAG_NEG]   <= w_fin_res[W-1];
                r_flags[FLAG_CARRY] <= w_fin_carry;
                r_flags[FLAG_ZERO]  <= (w_fin_res == '0);
                // Only SUB can set taken, and SUB is always single-cycle
                r_taken             <= w_load_sc && (w_op == ALU_SUB) && (inA == inB);
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign rslt      = r_rslt;
    assign flags     = r_flags;
    assign taken     = r_taken;

endmodule : alu_mc
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_mc
//  Description : Self-checking bench for alu_mc (W=8). A table of directed
//                vectors is followed by hand-written sequences for
//                backpressure, abort and reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_mc;
    import alu_pkg::*;

    localparam int W = 8;

    typedef struct {
        alu_op_e     op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [7:0]  exp_rslt;
        logic [2:0]  exp_flags;   // {neg, carry, zero}
        logic        exp_taken;
        int          exp_lat;
    } vec_t;

    logic          Clk = 1'b0;
    logic          Reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    ALUOp = 3'b000;
    logic [W-1:0]  inA = '0;
    logic [W-1:0]  inB = '0;
    logic          abort = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  rslt;
    logic [2:0]    flags;
    logic          taken;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t vecs[15];

    always #5 Clk = ~Clk;

    alu_mc #(.W(W)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ALUOp     (ALUOp),
        .inA       (inA),
        .inB       (inB),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rslt      (rslt),
        .flags     (flags),
        .taken     (taken)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Present one op, wait for out_valid (bounded), return the latency.
    // out_ready is kept low so the caller decides when the result is taken.
    task automatic issue(input alu_op_e op, input logic [7:0] a, input logic [7:0] b,
                         output int lat);
        @(negedge Clk);
        ALUOp = op; inA = a; inB = b; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge Clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge Clk); #1;
            lat++;
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        issue(v.op, v.a, v.b, lat);
        check($sformatf("v%0d latency", idx), lat, v.exp_lat);
        check($sformatf("v%0d rslt", idx), {24'd0, rslt}, {24'd0, v.exp_rslt});
        check($sformatf("v%0d flags", idx), {29'd0, flags}, {29'd0, v.exp_flags});
        check($sformatf("v%0d taken", idx), {31'd0, taken}, {31'd0, v.exp_taken});
        @(negedge Clk); out_ready = 1'b1;
        @(posedge Clk); #1;
        check($sformatf("v%0d out_valid drop", idx), {31'd0, out_valid}, 32'd0);
        @(negedge Clk); out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        vecs[0]  = '{ALU_ADD, 8'h7F, 8'h01, 8'h80, 3'b100, 1'b0, 1};
        vecs[1]  = '{ALU_SUB, 8'h11, 8'h11, 8'h00, 3'b001, 1'b1, 1};
        vecs[2]  = '{ALU_SUB, 8'h00, 8'h01, 8'hFF, 3'b110, 1'b0, 1};
        vecs[3]  = '{ALU_SHR, 8'hA0, 8'h06, 8'h02, 3'b010, 1'b0, 7};
        vecs[4]  = '{ALU_SHL, 8'h01, 8'h00, 8'h01, 3'b000, 1'b0, 1};
        vecs[5]  = '{ALU_MUL, 8'h10, 8'h11, 8'h10, 3'b010, 1'b0, 9};
        vecs[6]  = '{ALU_MUL, 8'h0F, 8'h0F, 8'hE1, 3'b100, 1'b0, 9};
        vecs[7]  = '{ALU_ADD, 8'hFF, 8'h01, 8'h00, 3'b011, 1'b0, 1};
        vecs[8]  = '{ALU_AND, 8'hF0, 8'h3C, 8'h30, 3'b000, 1'b0, 1};
        vecs[9]  = '{ALU_OR,  8'h0F, 8'h80, 8'h8F, 3'b100, 1'b0, 1};
        vecs[10] = '{ALU_XOR, 8'hAA, 8'hAA, 8'h00, 3'b001, 1'b0, 1};
        vecs[11] = '{ALU_SHL, 8'h81, 8'hF9, 8'h02, 3'b010, 1'b0, 2};  // amt uses inB[2:0] only
        vecs[12] = '{ALU_SHL, 8'h40, 8'h02, 8'h00, 3'b011, 1'b0, 3};
        vecs[13] = '{ALU_MUL, 8'hFF, 8'hFF, 8'h01, 3'b010, 1'b0, 9};
        vecs[14] = '{ALU_SUB, 8'h05, 8'h03, 8'h02, 3'b000, 1'b0, 1};

        // Reset values
        #12;
        check("reset in_ready", {31'd0, in_ready}, 32'd1);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset rslt", {24'd0, rslt}, 32'd0);
        check("reset flags", {29'd0, flags}, 32'd0);
        check("reset taken", {31'd0, taken}, 32'd0);
        @(negedge Clk); Reset_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            run_vec(vecs[i], i);
        end

        // Backpressure: result must hold, with no accept while out_ready is low
        issue(ALU_ADD, 8'h12, 8'h34, lat);
        check("bp latency", lat, 1);
        @(negedge Clk);
        ALUOp = ALU_ADD; inA = 8'h01; inB = 8'h01; in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge Clk); #1;
            check($sformatf("bp%0d rslt", c), {24'd0, rslt}, 32'h46);
            check($sformatf("bp%0d flags", c), {29'd0, flags}, 32'd0);
            check($sformatf("bp%0d in_ready", c), {31'd0, in_ready}, 32'd0);
            check($sformatf("bp%0d out_valid", c), {31'd0, out_valid}, 32'd1);
        end
        @(negedge Clk); in_valid = 1'b0; out_ready = 1'b1;
        @(posedge Clk); #1;
        check("bp release out_valid", {31'd0, out_valid}, 32'd0);
        check("bp release in_ready", {31'd0, in_ready}, 32'd1);
        check("bp release rslt hold", {24'd0, rslt}, 32'h46);
        @(negedge Clk); out_ready = 1'b0;
        repeat (3) @(posedge Clk);
        #1 check("bp no extra accept", {31'd0, out_valid}, 32'd0);

        // Abort in DONE discards the result; the next op runs normally
        issue(ALU_ADD, 8'h03, 8'h04, lat);
        check("abort-done lat", lat, 1);
        @(negedge Clk); abort = 1'b1;
        @(posedge Clk); #1;
        check("abort-done out_valid", {31'd0, out_valid}, 32'd0);
        check("abort-done in_ready", {31'd0, in_ready}, 32'd1);
        check("abort-done rslt hold", {24'd0, rslt}, 32'h07);
        @(negedge Clk); abort = 1'b0;
        run_vec('{ALU_SUB, 8'h09, 8'h04, 8'h05, 3'b000, 1'b0, 1}, 100);

        // Abort in IDLE blocks the transfer
        @(negedge Clk);
        ALUOp = ALU_ADD; inA = 8'h01; inB = 8'h02; in_valid = 1'b1; abort = 1'b1;
        @(posedge Clk); #1;
        in_valid = 1'b0; abort = 1'b0;
        check("abort-idle in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge Clk); #1;
        check("abort-idle out_valid", {31'd0, out_valid}, 32'd0);
        check("abort-idle rslt hold", {24'd0, rslt}, 32'h05);

        // Abort in BUSY: no result ever appears
        @(negedge Clk);
        ALUOp = ALU_MUL; inA = 8'h03; inB = 8'h05; in_valid = 1'b1;
        @(posedge Clk); #1; in_valid = 1'b0;
        check("abort-busy in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge Clk); abort = 1'b1;
        @(negedge Clk); abort = 1'b0;
        check("abort-busy in_ready after", {31'd0, in_ready}, 32'd1);
        lat = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge Clk); #1;
            if (out_valid) lat++;
        end
        check("abort-busy no out_valid", lat, 0);
        check("abort-busy rslt hold", {24'd0, rslt}, 32'h05);

        // Reset while MUL is busy clears outputs immediately
        @(negedge Clk);
        ALUOp = ALU_MUL; inA = 8'h07; inB = 8'h09; in_valid = 1'b1;
        @(posedge Clk); #1; in_valid = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk); Reset_n = 1'b0;
        #1;
        check("rst-busy rslt", {24'd0, rslt}, 32'd0);
        check("rst-busy out_valid", {31'd0, out_valid}, 32'd0);
        check("rst-busy in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge Clk); Reset_n = 1'b1;
        @(posedge Clk); #1;
        check("rst-release in_ready", {31'd0, in_ready}, 32'd1);
        lat = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge Clk); #1;
            if (out_valid) lat++;
        end
        check("rst-release op lost", lat, 0);
        run_vec(vecs[6], 200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_alu_mc
`default_nettype wire
